// File: rtl/path_runner_if.sv
// Answer-stack pop port and move handshake between path_runner and its neighbours.
// master: the path runner (pops the stack, sources moves).
// slave : the answer stack / motion sink side.
interface path_runner_if #(
  parameter int COORD_W = 4
);
  logic                   popa;
  logic                   emptya;
  logic [2*COORD_W-1:0]   dataa;
  logic [1:0]             move;
  logic                   move_valid;
  logic                   move_ready;

  modport master (
    output popa,
    output move,
    output move_valid,
    input  emptya,
    input  dataa,
    input  move_ready
  );

  modport slave (
    input  popa,
    input  move,
    input  move_valid,
    output emptya,
    output dataa,
    output move_ready
  );
endinterface

// File: rtl/path_runner.sv
// path_runner: replays the solved path held in the answer stack.
// Pops coordinates one at a time, turns each consecutive pair into a move
// code (00 +x, 01 -x, 10 +y, 11 -y) and offers it on a valid/ready handshake.
// Optional build macro PATH_CHECK_EN: when defined, a non-adjacent pair stops
// the replay in an error state with err raised; when undefined the check and
// the error state are not built and err is tied low.
module path_runner #(
  parameter int COORD_W = 4,
  parameter int STEP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  path_runner_if.master     bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [STEP_W-1:0] step_count
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_POP0,
    S_CAP0,
    S_CHK,
    S_POP,
    S_CAP,
    S_EMIT,
    S_DONE
`ifdef PATH_CHECK_EN
    , S_ERR
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic [2*COORD_W-1:0]   prev_q, prev_d;
  logic [2*COORD_W-1:0]   cur_q, cur_d;
  logic [1:0]             move_q, move_d;
  logic [STEP_W-1:0]      step_q, step_d;
  logic                   popa_c;
  logic                   move_valid_c;

  // Coordinates of the freshly popped entry and of the previous path point.
  logic [COORD_W-1:0] new_x, new_y, prev_x, prev_y;
  assign new_x  = bus.dataa[2*COORD_W-1:COORD_W];
  assign new_y  = bus.dataa[COORD_W-1:0];
  assign prev_x = prev_q[2*COORD_W-1:COORD_W];
  assign prev_y = prev_q[COORD_W-1:0];

  // Direction code, x has priority over y; equal points fall through to -y.
  logic [1:0] move_code;
  always_comb begin
    move_code = 2'b11;
    if (new_x > prev_x)      move_code = 2'b00;
    else if (new_x < prev_x) move_code = 2'b01;
    else if (new_y > prev_y) move_code = 2'b10;
    else                     move_code = 2'b11;
  end

`ifdef PATH_CHECK_EN
  // Adjacency uses unsigned distance so 15 -> 0 is not treated as a step.
  logic [COORD_W-1:0] dist_x, dist_y;
  logic               pair_adj;
  always_comb begin
    dist_x   = (new_x >= prev_x) ? (new_x - prev_x) : (prev_x - new_x);
    dist_y   = (new_y >= prev_y) ? (new_y - prev_y) : (prev_y - new_y);
    pair_adj = ((dist_x == COORD_W'(1)) && (dist_y == '0)) ||
               ((dist_x == '0) && (dist_y == COORD_W'(1)));
  end
`endif

  // Saturating increment of the accepted-move counter.
  logic [STEP_W-1:0] step_inc;
  assign step_inc = (step_q == '1) ? step_q : step_q + STEP_W'(1);

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    cur_d        = cur_q;
    move_d       = move_q;
    step_d       = step_q;
    popa_c       = 1'b0;
    move_valid_c = 1'b0;
    case (state_q)
      S_IDLE, S_DONE
`ifdef PATH_CHECK_EN
      , S_ERR
`endif
      : begin
        if (run) begin
          step_d  = '0;
          state_d = bus.emptya ? S_DONE : S_POP0;
        end
      end
      S_POP0: begin
        popa_c  = 1'b1;
        state_d = S_CAP0;
      end
      S_CAP0: begin
        prev_d  = bus.dataa;
        state_d = S_CHK;
      end
      S_CHK: begin
        state_d = bus.emptya ? S_DONE : S_POP;
      end
      S_POP: begin
        popa_c  = 1'b1;
        state_d = S_CAP;
      end
      S_CAP: begin
        cur_d   = bus.dataa;
        move_d  = move_code;
        state_d = S_EMIT;
`ifdef PATH_CHECK_EN
        if (!pair_adj) state_d = S_ERR;
`endif
      end
      S_EMIT: begin
        move_valid_c = 1'b1;
        if (bus.move_ready) begin
          step_d  = step_inc;
          prev_d  = cur_q;
          state_d = S_CHK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any entry already popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      prev_q  <= '0;
      cur_q   <= '0;
      move_q  <= 2'b00;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
      move_q  <= move_d;
      step_q  <= step_d;
    end
  end

  assign bus.popa       = popa_c;
  assign bus.move_valid = move_valid_c;
  assign bus.move       = move_q;
  assign step_count     = step_q;
  assign done           = (state_q == S_DONE);
`ifdef PATH_CHECK_EN
  assign err            = (state_q == S_ERR);
  assign busy           = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
`else
  assign err            = 1'b0;
  assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
`endif

endmodule

// File: tb/tb_path_runner.sv
// Bench for path_runner: a queue-based answer stack model, a scoreboard of
// expected moves checked by a monitor on every accepted handshake, and
// directed scenarios. A second instance with STEP_W=2 shadows the first to
// observe counter saturation.
module tb_path_runner;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  logic run;
  always #5 clk = ~clk;

  path_runner_if #(.COORD_W(CW)) bus ();
  path_runner_if #(.COORD_W(CW)) bus2 ();

  logic       busy, done, err;
  logic [7:0] step_count;
  logic       busy2, done2, err2;
  logic [1:0] step_count2;

  path_runner #(.COORD_W(CW), .STEP_W(8)) dut (
    .clk(clk), .rst(rst), .run(run), .bus(bus.master),
    .busy(busy), .done(done), .err(err), .step_count(step_count)
  );

  path_runner #(.COORD_W(CW), .STEP_W(2)) dut2 (
    .clk(clk), .rst(rst), .run(run), .bus(bus2.master),
    .busy(busy2), .done(done2), .err(err2), .step_count(step_count2)
  );

  // The shadow instance sees exactly the same stack and sink.
  assign bus2.emptya     = bus.emptya;
  assign bus2.dataa      = bus.dataa;
  assign bus2.move_ready = bus.move_ready;

  int         total = 0;
  int         bad   = 0;
  int         pop_cnt = 0;
  logic       last_pop = 1'b0;
  logic [7:0] stk[$];
  logic [1:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp_v);
    end else begin
      $display("ok   %s = %0d", nm, act);
    end
  endtask

  // Answer stack model: a pop seen in a cycle delivers data just after the edge.
  always begin
    @(negedge clk);
    if (bus.popa === 1'b1) begin
      pop_cnt++;
      chk("pop_while_nonempty", {31'd0, bus.emptya}, 32'd0);
      chk("pop_not_back_to_back", {31'd0, last_pop}, 32'd0);
      last_pop = 1'b1;
      @(posedge clk);
      #1;
      if (stk.size() > 0) bus.dataa = stk.pop_front();
      bus.emptya = (stk.size() == 0);
    end else begin
      last_pop = 1'b0;
    end
  end

  // Scoreboard monitor: every accepted move is matched against the queue.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.move_valid === 1'b1 && bus.move_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_move: got move %0d with no expected move queued", bus.move);
      end else begin
        chk("move", {30'd0, bus.move}, {30'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic do_run();
    @(posedge clk); #1;
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
  endtask

  task automatic wait_end(input string nm);
    int n;
    n = 0;
    while (!(done === 1'b1 || err === 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!(done === 1'b1 || err === 1'b1)) begin
      total++;
      bad++;
      $display("FAIL %s: got no done/err within 300 cycles, want done or err", nm);
    end
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (bus.move_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.move_valid !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s: got no move_valid within 50 cycles, want move_valid", nm);
    end
  endtask

  task automatic load_path(input logic [7:0] p[$]);
    stk = p;
    bus.emptya = (stk.size() == 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int cyc;
    int hold_ok;
    logic [7:0] p[$];

    rst = 1'b1;
    run = 1'b0;
    bus.move_ready = 1'b0;
    bus.emptya = 1'b1;
    bus.dataa = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_popa", {31'd0, bus.popa}, 0);
    chk("rst_move", {30'd0, bus.move}, 0);
    chk("rst_move_valid", {31'd0, bus.move_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_step", {24'd0, step_count}, 0);
    rst = 1'b0;

    // Path (0,0),(1,0),(1,1),(1,2): +x, +y, +y.
    p = '{8'h00, 8'h10, 8'h11, 8'h12};
    load_path(p);
    exp_q.push_back(2'b00); exp_q.push_back(2'b10); exp_q.push_back(2'b10);
    bus.move_ready = 1'b1;
    p0 = pop_cnt;
    do_run();
    cyc = 0;
    while (bus.move_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("first_move_latency", cyc, 5);
    wait_end("t1_end");
    @(negedge clk);
    chk("t1_done", {31'd0, done}, 1);
    chk("t1_err", {31'd0, err}, 0);
    chk("t1_step", {24'd0, step_count}, 3);
    chk("t1_pops", pop_cnt - p0, 4);
    chk("t1_moves_left", exp_q.size(), 0);

    // Empty stack at run: straight to DONE, counter cleared, no pops.
    stk.delete();
    bus.emptya = 1'b1;
    p0 = pop_cnt;
    do_run();
    chk("t2_done", {31'd0, done}, 1);
    chk("t2_busy", {31'd0, busy}, 0);
    chk("t2_step", {24'd0, step_count}, 0);
    repeat (3) @(negedge clk);
    chk("t2_pops", pop_cnt - p0, 0);

    // Path (2,2),(1,2) with the sink stalled for 10 cycles: -x held.
    p = '{8'h22, 8'h12};
    load_path(p);
    bus.move_ready = 1'b0;
    exp_q.push_back(2'b01);
    do_run();
    wait_valid("t3_valid");
    hold_ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.move_valid === 1'b1 && bus.move === 2'b01) hold_ok++;
    end
    chk("t3_stall_hold_cycles", hold_ok, 10);
    chk("t3_step_before_ready", {24'd0, step_count}, 0);
    @(posedge clk); #1;
    bus.move_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_step_after_ready", {24'd0, step_count}, 1);
    bus.move_ready = 1'b0;
    wait_end("t3_end");
    chk("t3_done", {31'd0, done}, 1);

    // Path (0,0),(2,0),(3,0): the first pair is two apart.
    p = '{8'h00, 8'h20, 8'h30};
    load_path(p);
    p0 = pop_cnt;
`ifdef PATH_CHECK_EN
    bus.move_ready = 1'b1;
    do_run();
    wait_end("t4_end");
    repeat (5) @(negedge clk);
    chk("t4_err", {31'd0, err}, 1);
    chk("t4_done", {31'd0, done}, 0);
    chk("t4_step", {24'd0, step_count}, 0);
    chk("t4_pops", pop_cnt - p0, 2);
    stk.delete();
    bus.emptya = 1'b1;
`else
    exp_q.push_back(2'b00); exp_q.push_back(2'b00);
    bus.move_ready = 1'b1;
    do_run();
    wait_end("t4_end");
    @(negedge clk);
    chk("t4_err", {31'd0, err}, 0);
    chk("t4_done", {31'd0, done}, 1);
    chk("t4_step", {24'd0, step_count}, 2);
    chk("t4_pops", pop_cnt - p0, 3);
`endif

    // Reset while a move is pending in EMIT, then a clean replay.
    p = '{8'h33, 8'h32, 8'h31};
    load_path(p);
    bus.move_ready = 1'b0;
    exp_q.push_back(2'b11);
    do_run();
    wait_valid("t5_valid1");
    @(posedge clk); #1;
    bus.move_ready = 1'b1;
    @(posedge clk); #1;
    bus.move_ready = 1'b0;
    wait_valid("t5_valid2");
    chk("t5_pre_rst_step", {24'd0, step_count}, 1);
    chk("t5_pre_rst_move", {30'd0, bus.move}, 3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_rst_popa", {31'd0, bus.popa}, 0);
    chk("t5_rst_move", {30'd0, bus.move}, 0);
    chk("t5_rst_move_valid", {31'd0, bus.move_valid}, 0);
    chk("t5_rst_busy", {31'd0, busy}, 0);
    chk("t5_rst_done", {31'd0, done}, 0);
    chk("t5_rst_err", {31'd0, err}, 0);
    chk("t5_rst_step", {24'd0, step_count}, 0);
    rst = 1'b0;
    exp_q.delete();
    p = '{8'h00, 8'h01, 8'h11};
    load_path(p);
    exp_q.push_back(2'b10); exp_q.push_back(2'b00);
    bus.move_ready = 1'b1;
    do_run();
    wait_end("t5_end");
    @(negedge clk);
    chk("t5_done", {31'd0, done}, 1);
    chk("t5_step", {24'd0, step_count}, 2);
    chk("t5_moves_left", exp_q.size(), 0);

    // Five +x moves: 8-bit counter reads 5, 2-bit counter saturates at 3.
    p = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    load_path(p);
    for (int i = 0; i < 5; i++) exp_q.push_back(2'b00);
    bus.move_ready = 1'b1;
    do_run();
    wait_end("t6_end");
    @(negedge clk);
    chk("t6_done", {31'd0, done}, 1);
    chk("t6_step", {24'd0, step_count}, 5);
    chk("t6_done_w2", {31'd0, done2}, 1);
    chk("t6_step_w2_sat", {30'd0, step_count2}, 3);
    chk("t6_moves_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
